// File: rtl/riscv_multicycle_control.sv
// riscv_multicycle_control: main control FSM of the multicycle RV32 core.
// Steps each instruction through FETCH / DECODE / EXECUTE / MEMORY / WRITEBACK
// and drives the datapath mux selects, write enables and the 2-bit alu_op.
// It also counts retired instructions.
// Optional feature macro: MC_CTRL_JAL_EN (adds the JAL state for opcode 1101111).
//
// Memory handshake: mem_read/mem_write are requests that stay asserted, with
// the same iord, for every cycle of a wait state. The access completes in the
// cycle mem_ready is high, and only that cycle advances the FSM. There is no timeout.
module riscv_multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [1:0]       alu_op,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             pc_write,
  output logic             pc_source,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic [1:0]       mem_to_reg,
  output logic             illegal,
  output logic             instr_retired,
  output logic [CNT_W-1:0] retired_count,
  output logic [3:0]       dbg_state
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EXEC_R    = 4'd2,
    S_ALU_WB    = 4'd3,
    S_MEM_ADDR  = 4'd4,
    S_MEM_READ  = 4'd5,
    S_MEM_WB    = 4'd6,
    S_MEM_WRITE = 4'd7,
    S_BRANCH    = 4'd8,
    S_JAL       = 4'd9
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_count;

  // State register; reset always lands in FETCH.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  // Next-state and output decode. Everything defaults to 0, and reset forces all outputs to 0.
  always_comb begin
    w_next        = S_FETCH;
    alu_op        = 2'd0;
    alu_src_a     = 2'd0;
    alu_src_b     = 2'd0;
    pc_write      = 1'b0;
    pc_source     = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 2'd0;
    illegal       = 1'b0;
    instr_retired = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        w_next    = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Branch target (old PC + imm) lands in ALUOut for a possible BRANCH.
        alu_src_a = 2'd2;
        alu_src_b = 2'd2;
        case (opcode)
          OP_R:               w_next = S_EXEC_R;
          OP_LOAD, OP_STORE:  w_next = S_MEM_ADDR;
          OP_BRANCH:          w_next = S_BRANCH;
`ifdef MC_CTRL_JAL_EN
          OP_JAL:             w_next = S_JAL;
`endif
          default: begin
            illegal = 1'b1;
            w_next  = S_FETCH;
          end
        endcase
      end
      S_EXEC_R: begin
        alu_src_a = 2'd1;
        alu_op    = 2'b10;
        w_next    = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write     = 1'b1;
        instr_retired = 1'b1;
      end
      S_MEM_ADDR: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd2;
        w_next    = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        w_next   = mem_ready ? S_MEM_WB : S_MEM_READ;
      end
      S_MEM_WB: begin
        reg_write     = 1'b1;
        mem_to_reg    = 2'd1;
        instr_retired = 1'b1;
      end
      S_MEM_WRITE: begin
        iord          = 1'b1;
        mem_write     = 1'b1;
        instr_retired = mem_ready;
        w_next        = mem_ready ? S_FETCH : S_MEM_WRITE;
      end
      S_BRANCH: begin
        alu_src_a     = 2'd1;
        alu_op        = 2'b01;
        pc_source     = 1'b1;
        pc_write      = zero;
        instr_retired = 1'b1;
      end
`ifdef MC_CTRL_JAL_EN
      S_JAL: begin
        // PC already holds old PC + 4, so the link value is written before the PC load takes effect.
        pc_write      = 1'b1;
        pc_source     = 1'b1;
        reg_write     = 1'b1;
        mem_to_reg    = 2'd2;
        instr_retired = 1'b1;
      end
`endif
      default: w_next = S_FETCH;
    endcase
    if (reset) begin
      alu_op        = 2'd0;
      alu_src_a     = 2'd0;
      alu_src_b     = 2'd0;
      pc_write      = 1'b0;
      pc_source     = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      mem_to_reg    = 2'd0;
      illegal       = 1'b0;
      instr_retired = 1'b0;
    end
  end

  // Retired-instruction counter. It wraps naturally from all-ones to 0.
  always_ff @(posedge clk) begin
    if (reset)              r_count <= '0;
    else if (instr_retired) r_count <= r_count + CNT_W'(1);
  end

  assign retired_count = reset ? '0 : r_count;
  assign dbg_state     = reset ? 4'd0 : r_state;

endmodule

// File: tb/tb_riscv_multicycle_control.sv
// Testbench for riscv_multicycle_control.
// A small 4-bit counter makes the wrap from all-ones reachable in a short run.
// The expected per-cycle outputs come from an instruction-level model of the
// control sequence. Extra literal checks pin the cycle counts and the retire totals.
module tb_riscv_multicycle_control;

  localparam int CW    = 4;
  localparam int CTL_W = 17;
  localparam int EXP_W = CTL_W + CW;
`ifdef MC_CTRL_JAL_EN
  localparam int JAL_N = 1;
`else
  localparam int JAL_N = 0;
`endif

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  typedef struct packed {
    logic [1:0] alu_op;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic       pc_write;
    logic       pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic       illegal;
    logic       retired;
  } ctl_t;

  logic          clk;
  logic          reset;
  logic [6:0]    opcode;
  logic          zero;
  logic          mem_ready;
  logic [1:0]    alu_op, alu_src_a, alu_src_b, mem_to_reg;
  logic          pc_write, pc_source, iord, mem_read, mem_write;
  logic          ir_write, reg_write, illegal, instr_retired;
  logic [CW-1:0] retired_count;
  logic [3:0]    dbg_state;
  ctl_t          dut_ctl;

  riscv_multicycle_control #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_write(pc_write), .pc_source(pc_source), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .illegal(illegal),
    .instr_retired(instr_retired), .retired_count(retired_count), .dbg_state(dbg_state)
  );

  assign dut_ctl = {alu_op, alu_src_a, alu_src_b, pc_write, pc_source, iord, mem_read,
                    mem_write, ir_write, reg_write, mem_to_reg, illegal, instr_retired};

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard state
  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] e_vec;
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int model_cnt = 0;
  int len = 0, last_len = 0, n_ret = 0, n_ill = 0, n_ir = 0, n_reg = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  // Compare process: every cycle that has a model expectation, plus the DUT event tallies.
  always @(negedge clk) begin
    cyc++;
    if (exp_q.size() > 0) begin
      e_vec = exp_q.pop_front();
      check("ctl", 32'(dut_ctl), 32'(e_vec[EXP_W-1:CW]));
      check("retired_count", 32'(retired_count), 32'(e_vec[CW-1:0]));
    end
    if (reset) len = 0;
    else begin
      len++;
      if (instr_retired) begin last_len = len; len = 0; n_ret++; end
      if (illegal) begin len = 0; n_ill++; end
      if (ir_write) n_ir++;
      if (reg_write) n_reg++;
    end
  end

  function automatic logic [6:0] rnd7();
    return 7'($urandom_range(0, 127));
  endfunction

  function automatic logic rnd1();
    return 1'($urandom_range(0, 1));
  endfunction

  // Drivers: one call covers one clock cycle and queues the expected outputs for that cycle.
  task automatic step(input logic rst, input logic [6:0] op, input logic mr, input logic z,
                      input ctl_t e);
    ctl_t zc;
    zc = '0;
    @(posedge clk); #1;
    reset = rst; opcode = op; mem_ready = mr; zero = z;
    if (rst) begin
      exp_q.push_back({zc, CW'(0)});
      model_cnt = 0;
    end else begin
      exp_q.push_back({e, model_cnt[CW-1:0]});
      if (e.retired) model_cnt = (model_cnt + 1) % (1 << CW);
    end
  endtask

  task automatic peek();
    @(negedge clk); #1;
  endtask

  // Instruction classes: 0 R, 1 load, 2 store, 3 branch, 4 jal, 5 illegal.
  function automatic int kind(input logic [6:0] op);
    if (op == OP_R) return 0;
    if (op == OP_LW) return 1;
    if (op == OP_SW) return 2;
    if (op == OP_BEQ) return 3;
    if (JAL_N == 1 && op == OP_JAL) return 4;
    return 5;
  endfunction

  task automatic do_fetch(input int fw, input int lit_cnt);
    ctl_t e;
    for (int i = 0; i <= fw; i++) begin
      e = '0;
      e.mem_read = 1'b1;
      e.src_b    = 2'd1;
      e.ir_write = (i == fw);
      e.pc_write = (i == fw);
      step(1'b0, rnd7(), (i == fw), rnd1(), e);
      if (i == 0 && lit_cnt >= 0) begin
        peek();
        check("count_lit", 32'(retired_count), 32'(lit_cnt));
      end
    end
  endtask

  task automatic do_decode(input logic [6:0] op);
    ctl_t e;
    e = '0;
    e.src_a = 2'd2;
    e.src_b = 2'd2;
    e.illegal = (kind(op) == 5);
    step(1'b0, op, rnd1(), rnd1(), e);
  endtask

  task automatic run_instr(input logic [6:0] op, input int fw, input int mw, input logic z,
                           input int lit_cnt);
    ctl_t e;
    int   k;
    k = kind(op);
    do_fetch(fw, lit_cnt);
    do_decode(op);
    if (k == 0) begin
      e = '0; e.src_a = 2'd1; e.alu_op = 2'b10;
      step(1'b0, op, rnd1(), rnd1(), e);
      e = '0; e.reg_write = 1'b1; e.retired = 1'b1;
      step(1'b0, op, rnd1(), rnd1(), e);
    end else if (k == 1 || k == 2) begin
      e = '0; e.src_a = 2'd1; e.src_b = 2'd2;
      step(1'b0, op, rnd1(), rnd1(), e);
      for (int i = 0; i <= mw; i++) begin
        e = '0; e.iord = 1'b1;
        if (k == 1) e.mem_read = 1'b1;
        else begin e.mem_write = 1'b1; e.retired = (i == mw); end
        step(1'b0, op, (i == mw), rnd1(), e);
      end
      if (k == 1) begin
        e = '0; e.reg_write = 1'b1; e.mem_to_reg = 2'd1; e.retired = 1'b1;
        step(1'b0, op, rnd1(), rnd1(), e);
      end
    end else if (k == 3) begin
      e = '0; e.src_a = 2'd1; e.alu_op = 2'b01; e.pc_source = 1'b1;
      e.pc_write = z; e.retired = 1'b1;
      step(1'b0, op, rnd1(), z, e);
    end else if (k == 4) begin
      e = '0; e.pc_write = 1'b1; e.pc_source = 1'b1; e.reg_write = 1'b1;
      e.mem_to_reg = 2'd2; e.retired = 1'b1;
      step(1'b0, op, rnd1(), rnd1(), e);
    end
  endtask

  // A load cut short by reset while it waits in the memory-read phase.
  task automatic lw_abort();
    ctl_t e;
    do_fetch(0, -1);
    do_decode(OP_LW);
    e = '0; e.src_a = 2'd1; e.src_b = 2'd2;
    step(1'b0, OP_LW, rnd1(), rnd1(), e);
    e = '0; e.iord = 1'b1; e.mem_read = 1'b1;
    step(1'b0, OP_LW, 1'b0, rnd1(), e);
    e = '0;
    step(1'b1, OP_LW, 1'b0, rnd1(), e);
    step(1'b1, OP_LW, 1'b1, rnd1(), e);
  endtask

  // Directed sequence
  initial begin
    ctl_t zc;
    zc = '0;
    reset = 1'b1; opcode = '0; zero = 1'b0; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, rnd7(), rnd1(), rnd1(), zc);

    run_instr(OP_R, 0, 0, 1'b0, -1);
    run_instr(OP_LW, 3, 3, 1'b0, 1);
    peek();
    check("lw_len", 32'(last_len), 32'd11);
    check("ir_write_total_lw", 32'(n_ir), 32'd2);

    run_instr(OP_BEQ, 0, 0, 1'b1, 2);
    run_instr(OP_BEQ, 1, 0, 1'b0, -1);
    run_instr(OP_SW, 0, 2, 1'b0, -1);
    peek();
    check("sw_len", 32'(last_len), 32'd6);
    check("reg_write_total_sw", 32'(n_reg), 32'd2);

    run_instr(OP_BAD, 0, 0, 1'b0, 5);
    peek();
    check("illegal_total", 32'(n_ill), 32'd1);
    run_instr(OP_JAL, 0, 0, 1'b0, -1);
    run_instr(OP_R, 0, 0, 1'b0, 5 + JAL_N);

    while (model_cnt != 15) run_instr(OP_BEQ, 0, 0, rnd1(), -1);
    run_instr(OP_R, 0, 0, 1'b0, 15);
    run_instr(OP_R, 0, 0, 1'b0, 0);
    lw_abort();
    run_instr(OP_R, 0, 0, 1'b0, 0);
    peek();
    check("retire_total", 32'(n_ret), 32'd18);
    check("illegal_final", 32'(n_ill), 32'(2 - JAL_N));
    check("ir_write_final", 32'(n_ir), 32'(21 - JAL_N));
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
